// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that puts a core data port and a return-address-stack spill/fill
// port onto one memory port, one transaction at a time, with a timeout on m_rdy.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_be,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  output logic        c_hold,
  input  logic        r_req,
  input  logic        r_we,
  input  logic [31:0] r_addr,
  input  logic [31:0] r_wdata,
  output logic [31:0] r_rdata,
  output logic        r_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_rdy,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;    // 0 = core, 1 = RAS
  logic        prio_q, prio_d;  // requester that wins a tie
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] r_rdata_q, r_rdata_d;
  logic        win;
  logic        set_err;
  logic [31:0] resp_data;
  logic        resp_load;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    c_rdata_d = c_rdata_q;
    r_rdata_d = r_rdata_q;
    win       = 1'b0;
    set_err   = 1'b0;
    resp_data = m_rdata;
    resp_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (c_req || r_req) begin
          win       = (c_req && r_req) ? prio_q : r_req;
          gnt_d     = win;
          m_we_d    = win ? r_we    : c_we;
          m_addr_d  = win ? r_addr  : c_addr;
          m_wdata_d = win ? r_wdata : c_wdata;
          m_be_d    = win ? 4'hF    : c_be;
          cnt_d     = 16'd0;
          state_d   = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        // A real completion beats a timeout landing in the same cycle.
        if (m_rdy) begin
          resp_load = 1'b1;
          state_d   = RESP;
        end else if (cnt_q == TIMEOUT_CNT) begin
          resp_data = ERR_DATA;
          resp_load = 1'b1;
          set_err   = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        prio_d  = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resp_load) begin
      if (gnt_q) r_rdata_d = resp_data;
      else       c_rdata_d = resp_data;
    end

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (set_err) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      prio_q    <= 1'b0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'h0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      c_rdata_q <= 32'd0;
      r_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      c_rdata_q <= c_rdata_d;
      r_rdata_q <= r_rdata_d;
    end
  end

  assign m_en    = (state_q == ISSUE);
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign c_ack   = (state_q == RESP) && !gnt_q;
  assign r_ack   = (state_q == RESP) &&  gnt_q;
  assign c_hold  = c_req & ~c_ack;
  assign c_rdata = c_rdata_q;
  assign r_rdata = r_rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and responses are queued when a
// request is driven and compared when the matching ack appears.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk, Rst;
  logic        c_req, c_we, r_req, r_we;
  logic [31:0] c_addr, c_wdata, r_addr, r_wdata;
  logic [3:0]  c_be;
  logic [31:0] c_rdata, r_rdata;
  logic        c_ack, c_hold, r_ack;
  logic        m_en, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_rdy, err, err_clr;

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .Rst(Rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_hold(c_hold),
    .r_req(r_req), .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_rdata(r_rdata), .r_ack(r_ack),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_rdy(m_rdy), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        er;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_c = 32'd0, last_r = 32'd0;
  bit          last_c_v = 1'b1, last_r_v = 1'b1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input bit who, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] rd, input logic er);
    exp_t e;
    e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    e.be = who ? 4'hF : be; e.rdata = rd; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic core_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
    c_we = we; c_addr = addr; c_wdata = wdata; c_be = be; c_req = 1'b1;
  endtask

  task automatic ras_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    r_we = we; r_addr = addr; r_wdata = wdata; r_req = 1'b1;
  endtask

  // dly: cycles after the issue cycle that m_rdy arrives (0 = during issue, <0 = never)
  task automatic serve_one(input int dly, input bit drop);
    exp_t e;
    bit   seen;
    int   lat, explat;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q[0];
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_en) begin seen = 1'b1; break; end
      tick();
    end
    chk("men_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("m_we", 32'(m_we), 32'(e.we));
    chk("m_addr", m_addr, e.addr);
    chk("m_wdata", m_wdata, e.wdata);
    chk("m_be", 32'(m_be), 32'(e.be));
    chk("c_hold_busy", 32'(c_hold), 32'(c_req));
    if (dly == 0) begin m_rdy = 1'b1; m_rdata = e.rdata; end
    tick();
    m_rdy = 1'b0;
    lat = 1;
    chk("men_pulse", 32'(m_en), 32'd0);
    if (dly > 0) begin
      repeat (dly - 1) begin tick(); lat++; end
      m_rdy = 1'b1; m_rdata = e.rdata;
      tick(); lat++;
      m_rdy = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (c_ack || r_ack) begin seen = 1'b1; break; end
      tick(); lat++;
    end
    chk("ack_seen", 32'(seen), 32'd1);
    if (!seen) return;
    void'(exp_q.pop_front());
    explat = (dly < 0) ? TO + 1 : ((dly == 0) ? 1 : dly + 1);
    chk("latency", 32'(lat), 32'(explat));
    chk("ack_vec", 32'({c_ack, r_ack}), e.who ? 32'd1 : 32'd2);
    if (!e.we) chk("rdata", e.who ? r_rdata : c_rdata, e.rdata);
    if (e.who && last_c_v)  chk("c_rdata_hold", c_rdata, last_c);
    if (!e.who && last_r_v) chk("r_rdata_hold", r_rdata, last_r);
    if (e.who) begin last_r = e.rdata; last_r_v = !e.we; end
    else       begin last_c = e.rdata; last_c_v = !e.we; end
    chk("err", 32'(err), 32'(e.er));
    if (drop) begin c_req = 1'b0; r_req = 1'b0; end
    tick();
    chk("ack_pulse", 32'({c_ack, r_ack}), 32'd0);
    chk("c_hold_after", 32'(c_hold), 32'(c_req));
  endtask

  initial begin
    bit seen;
    Rst = 1'b1; c_req = 1'b0; r_req = 1'b0; c_we = 1'b0; r_we = 1'b0;
    c_addr = '0; c_wdata = '0; c_be = '0; r_addr = '0; r_wdata = '0;
    m_rdata = '0; m_rdy = 1'b0; err_clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_acks", 32'({c_ack, r_ack}), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_r_rdata", r_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    Rst = 1'b0;
    tick();

    // single core read
    core_drive(1'b0, 32'h100, 32'h0, 4'hF);
    push(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    serve_one(1, 1'b1);

    // core byte write then RAS write
    core_drive(1'b1, 32'h200, 32'hA5A5_A5A5, 4'b0010);
    push(1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0);
    serve_one(2, 1'b1);
    ras_drive(1'b1, 32'h300, 32'h1122_3344);
    push(1'b1, 1'b1, 32'h300, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    serve_one(0, 1'b1);

    // both requesting: alternate starting with core (last served was RAS)
    core_drive(1'b0, 32'h400, 32'h0, 4'hF);
    ras_drive(1'b0, 32'h500, 32'h0);
    push(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h1111_0000, 1'b0);
    push(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 32'h2222_0000, 1'b0);
    push(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h3333_0000, 1'b0);
    push(1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 32'h4444_0000, 1'b0);
    serve_one(0, 1'b0);
    serve_one(1, 1'b0);
    serve_one(0, 1'b0);
    serve_one(3, 1'b1);

    // timeout, then clear
    core_drive(1'b0, 32'h600, 32'h0, 4'hF);
    push(1'b0, 1'b0, 32'h600, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    serve_one(-1, 1'b1);
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // timeout while err_clr held: set wins
    err_clr = 1'b1;
    ras_drive(1'b0, 32'h680, 32'h0);
    push(1'b1, 1'b0, 32'h680, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
    serve_one(-1, 1'b1);
    err_clr = 1'b0;
    chk("err_clr_held", 32'(err), 32'd0);

    // m_rdy on the exact timeout cycle
    core_drive(1'b0, 32'h6C0, 32'h0, 4'hF);
    push(1'b0, 1'b0, 32'h6C0, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
    serve_one(TO, 1'b1);

    // reset during WAIT aborts the transaction
    core_drive(1'b0, 32'h700, 32'h0, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_en) begin seen = 1'b1; break; end
      tick();
    end
    chk("abort_men_seen", 32'(seen), 32'd1);
    tick();
    Rst = 1'b1; c_req = 1'b0;
    tick();
    Rst = 1'b0;
    last_c = 32'd0; last_r = 32'd0; last_c_v = 1'b1; last_r_v = 1'b1;
    chk("abort_c_rdata", c_rdata, 32'd0);
    chk("abort_m_en", 32'(m_en), 32'd0);
    m_rdy = 1'b1; m_rdata = 32'h9999_9999;
    tick();
    m_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_ack", 32'({c_ack, r_ack, m_en}), 32'd0);
      tick();
    end
    chk("abort_c_rdata_kept", c_rdata, 32'd0);

    // priority back to core after reset
    core_drive(1'b0, 32'h800, 32'h0, 4'hF);
    ras_drive(1'b0, 32'h900, 32'h0);
    push(1'b0, 1'b0, 32'h800, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
    serve_one(1, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles to wait for m_rdy after issue, range 1..65535.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 Rst  in  1  reset, synchronous and active-high.
REQ-005 c_req, c_we  in  1,1  core data request (level) and write enable.
REQ-006 c_addr, c_wdata  in  32,32  core address and write data; c_be  in  4  core byte enables.
REQ-007 c_rdata  out  32  core read data; c_ack  out  1  one-cycle completion pulse; c_hold  out  1  core stall.
REQ-008 r_req, r_we  in  1,1  return-address-stack spill/fill request (level) and write enable.
REQ-009 r_addr, r_wdata  in  32,32  spill/fill address and write data (always full word).
REQ-010 r_rdata  out  32  spill/fill read data; r_ack  out  1  one-cycle completion pulse.
REQ-011 m_en, m_we  out  1,1  shared memory port strobe and write enable; m_be  out  4  byte enables.
REQ-012 m_addr, m_wdata  out  32,32  shared port address and write data.
REQ-013 m_rdata  in  32  port read data; m_rdy  in  1  port completion, valid for one cycle.
REQ-014 err  out  1  sticky timeout flag; err_clr  in  1  clears err.

Function
REQ-015 The block SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-016 Requesters SHALL hold req and all command fields stable from assertion until their ack; the arbiter SHALL sample them only in IDLE.
REQ-017 IDLE: if any req, the arbiter SHALL select a winner, register its command, set gnt, and go to ISSUE; else stay IDLE.
REQ-018 Arbitration SHALL be round-robin: a 1-bit last-grant pointer gives priority to the requester not served last; after reset priority is core.
REQ-019 ISSUE: m_en SHALL be 1 for exactly this one cycle with registered m_we/m_addr/m_wdata/m_be; m_be = c_be for core, 4'hF for RAS; next state WAIT, or RESP if m_rdy=1 in this cycle.
REQ-020 WAIT: m_en=0; on m_rdy go to RESP; m_rdy in any state other than ISSUE/WAIT SHALL be ignored.
REQ-021 On accepted m_rdy the arbiter SHALL register m_rdata into the response register (also on writes; value then don't-care).
REQ-022 RESP: ack of the granted requester SHALL be 1 for exactly this cycle with rdata valid, last-grant pointer updated, next state IDLE; the other ack SHALL stay 0.
REQ-023 Minimum latency req->ack SHALL be 2 cycles (IDLE sample, ISSUE with m_rdy, ack in RESP = 3rd edge); back-to-back transactions SHALL issue every 3 cycles.
REQ-024 c_rdata/r_rdata SHALL hold their last value between acks.
REQ-025 c_hold SHALL equal c_req & ~c_ack (combinational).
REQ-026 A 16-bit wait counter SHALL clear on entering ISSUE and increment each cycle in ISSUE/WAIT without m_rdy; when it reaches TIMEOUT, state SHALL go to RESP with response data ERR_DATA and err set.
REQ-027 m_rdy in the same cycle the counter reaches TIMEOUT SHALL win: real data returned, err unchanged.
REQ-028 err SHALL be set by timeout, cleared by err_clr; simultaneous set and clear SHALL leave err=1.
REQ-029 A requester dropping req before ack is a protocol violation; the in-flight transaction SHALL still complete and ack.

Reset
REQ-030 Rst SHALL force state IDLE, pointer to core, counter 0, err 0, c_ack/r_ack/m_en/m_we 0, m_be 0, m_addr/m_wdata/c_rdata/r_rdata 0, with priority over all other inputs.
REQ-031 Rst in ISSUE/WAIT/RESP SHALL abort the transaction with no ack; a later m_rdy SHALL be ignored.

Verification
REQ-032 Single core read c_addr=0x100, m_rdy one cycle after m_en, m_rdata=0x12345678 -> one m_en pulse, c_ack one cycle with c_rdata=0x12345678, c_hold low the cycle after ack.
REQ-033 c_req and r_req held together for 4 transactions -> grant order core, RAS, core, RAS; no ack overlap.
REQ-034 Core byte write c_be=4'b0010 and RAS write -> m_be 4'b0010 then 4'hF, m_wdata matches each.
REQ-035 TIMEOUT=4, m_rdy never -> ack on schedule with rdata=0xDEADBEEF, err=1; err_clr pulse -> err=0.
REQ-036 m_rdy on the exact TIMEOUT cycle -> real data, err stays 0.
REQ-037 Rst asserted in WAIT, then m_rdy -> no ack, state IDLE, next request handled normally with core priority.
